// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_ctrl
// Purpose  : Display peripheral controller. It turns bus store strobes into
//            value-register writes and a latched display config. It also
//            time-multiplexes the four nibbles of the value register onto a
//            4-digit common-anode 7-segment display. Each digit slot starts
//            with an all-anodes-off dead time, and the controller supports a
//            per-digit enable mask and leading-zero blanking.
// Ports    : clk_10MHz_i  - system clock
//            rst_i        - asynchronous active-high reset
//            wr_en_i      - store strobe to the display value address
//            wr_cfg_i     - store strobe to the display config address
//            wr_data_i    - store data (value: [15:0], config: [4]=lzb, [3:0]=mask)
//            reg_we_o     - one-cycle write enable to the value register
//            reg_d_o      - write data to the value register
//            reg_q_i      - value register read-back
//            an_o         - digit anodes, active-low, bit k = digit k
//            seg_o        - segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_ctrl #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int DEAD_CYC   = 100
) (
    input  logic        clk_10MHz_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic        wr_cfg_i,
    input  logic [31:0] wr_data_i,
    output logic        reg_we_o,
    output logic [15:0] reg_d_o,
    input  logic [15:0] reg_q_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int SLOT_CYC = CLK_HZ / (4 * REFRESH_HZ);
    localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] c_SLOT_LAST = CNT_W'(SLOT_CYC - 1);

    localparam logic [0:0] c_ST_DEAD  = 1'b0;
    localparam logic [0:0] c_ST_DRIVE = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap;
    logic [3:0]       r_mask;
    logic             r_lzb;
    logic             r_we;
    logic [15:0]      r_d;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_slot_start;
    logic             w_slot_end;
    logic [15:0]      w_snap;
    logic [3:0]       w_nib;
    logic [3:1]       w_zero_from;
    logic [3:0]       w_blank;
    logic [3:0]       w_shown;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic [15:0]      w_unused_data;

    assign w_unused_data = wr_data_i[31:16];

    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Bus write path: value-register strobe and config latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_we   <= 1'b0;
            r_d    <= 16'h0000;
            r_mask <= 4'hF;
            r_lzb  <= 1'b0;
        end else begin
            r_we <= wr_en_i;
            if (wr_en_i) begin
                r_d <= wr_data_i[15:0];
            end
            if (wr_cfg_i) begin
                r_mask <= wr_data_i[3:0];
                r_lzb  <= wr_data_i[4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_DEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_DEAD: begin
                if (r_cnt == c_DEAD_LAST) begin
                    w_state_nxt = c_ST_DRIVE;
                end
            end
            c_ST_DRIVE: begin
                if (r_cnt == c_SLOT_LAST) begin
                    w_state_nxt = c_ST_DEAD;
                end
            end
            default: w_state_nxt = c_ST_DEAD;
        endcase
    end

    assign w_slot_start = (r_state == c_ST_DEAD)  && (r_cnt == c_CNT_ZERO);
    assign w_slot_end   = (r_state == c_ST_DRIVE) && (r_cnt == c_SLOT_LAST);

    // Slot counter, digit index and per-slot snapshot of the value register.
    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= c_CNT_ZERO;
            r_idx  <= 2'd0;
            r_snap <= 16'h0000;
        end else begin
            if (w_slot_end) begin
                r_cnt <= c_CNT_ZERO;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_slot_start) begin
                r_snap <= reg_q_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: output logic
    // ------------------------------------------------------------------
    // On the slot's first cycle the snapshot register has not been loaded
    // yet. Bypass to the live value so that a single-cycle dead time still
    // decodes the fresh snapshot.
    assign w_snap = w_slot_start ? reg_q_i : r_snap;
    assign w_nib  = w_snap[{r_idx, 2'b00} +: 4];

    // w_zero_from[k]: nibbles k..3 of the snapshot are all zero.
    assign w_zero_from[3] = (w_snap[15:12] == 4'h0);
    assign w_zero_from[2] = w_zero_from[3] && (w_snap[11:8] == 4'h0);
    assign w_zero_from[1] = w_zero_from[2] && (w_snap[7:4]  == 4'h0);

    assign w_blank = {w_zero_from & {3{r_lzb}}, 1'b0};
    assign w_shown = r_mask & ~w_blank;

    // The pins are registered from the next state. The digit index only
    // changes on entry to DEAD, so r_idx is already the index whenever the
    // next state is DRIVE.
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 7'h7F;
        if ((w_state_nxt == c_ST_DRIVE) && w_shown[r_idx]) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = f_hex7(w_nib);
        end
    end

    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an_o     = r_an;
    assign seg_o    = r_seg;
    assign reg_we_o = r_we;
    assign reg_d_o  = r_d;

endmodule
`default_nettype wire
